// File: rtl/slow_clk_pkg.sv
// rtl/slow_clk_pkg.sv - shared types and constants for the slow-tick BCD counter
package slow_clk_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decade of the BCD counter; carries out when incremented at 9
module bcd_digit
  import slow_clk_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry_out
);

  assign carry_out = inc && (q == BCD_MAX);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= carry_out ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/slow_tick_bcd_counter.sv
// rtl/slow_tick_bcd_counter.sv - synchronizes a divided clock into ticks and counts them in BCD
module slow_tick_bcd_counter
  import slow_clk_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_n,
  input  logic                        slow_clk_in,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        clear,
  output logic [BCD_W*NUM_DIGITS-1:0] count_bcd,
  output logic                        tick_out,
  output logic                        running,
  output logic                        wrap
);

  localparam int ARM_CNT = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_CNT + 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;
  logic                   sync_prev;
  logic [ARM_W-1:0]       arm_cnt;
  logic                   armed;
  logic                   rise;
  state_t                 state;
  logic [NUM_DIGITS:0]    carry;

  assign sync_q = sync_ff[SYNC_STAGES-1];
  assign armed  = (arm_cnt == ARM_W'(ARM_CNT));
  // Arming masks the edge seen when slow_clk_in is already high at reset release.
  assign rise   = sync_q && !sync_prev && armed;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync_ff   <= '0;
      sync_prev <= 1'b0;
      arm_cnt   <= '0;
      tick_out  <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      sync_ff   <= {sync_ff[SYNC_STAGES-2:0], slow_clk_in};
      sync_prev <= sync_q;
      if (!armed) begin
        arm_cnt <= arm_cnt + ARM_W'(1);
      end
      tick_out  <= rise;
      wrap      <= carry[NUM_DIGITS];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state <= STOPPED;
    end else begin
      case (state)
        STOPPED: if (start && !stop) state <= RUNNING;
        RUNNING: if (stop) state <= STOPPED;
        default: state <= STOPPED;
      endcase
    end
  end

  assign running = (state == RUNNING);

  // Clear gates the increment so a coincident rise can neither count nor wrap.
  assign carry[0] = rise && (state == RUNNING) && !clear;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    bcd_digit u_digit (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .clr       (clear),
      .inc       (carry[d]),
      .q         (count_bcd[d*BCD_W +: BCD_W]),
      .carry_out (carry[d+1])
    );
  end

endmodule
